// File: rtl/nic_fifo.sv
// nic_fifo: CPU <-> mesh-router NIC with independent input and output packet FIFOs.
// Occupancy is counter-based, so an all-zero packet is an ordinary valid packet.
module nic_fifo #(
   parameter int PACKET_WIDTH = 64,
   parameter int IN_DEPTH     = 4,
   parameter int OUT_DEPTH    = 4
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [1:0]              addr,
   input  logic [PACKET_WIDTH-1:0] d_in,
   output logic [PACKET_WIDTH-1:0] d_out,
   input  logic                    nicEn,
   input  logic                    nicEnWR,
   input  logic                    net_si,
   output logic                    net_ri,
   input  logic [PACKET_WIDTH-1:0] net_di,
   output logic                    net_so,
   input  logic                    net_ro,
   output logic [PACKET_WIDTH-1:0] net_do,
   input  logic                    net_polarity
);
   localparam int IAW = $clog2(IN_DEPTH);
   localparam int OAW = $clog2(OUT_DEPTH);
   localparam int ICW = IAW + 1;
   localparam int OCW = OAW + 1;
   localparam logic [IAW:0] IN_FULL  = ICW'(IN_DEPTH);
   localparam logic [OAW:0] OUT_FULL = OCW'(OUT_DEPTH);

   logic [PACKET_WIDTH-1:0] r_in_mem  [IN_DEPTH];
   logic [PACKET_WIDTH-1:0] r_out_mem [OUT_DEPTH];
   logic [IAW-1:0]          r_in_wp, r_in_rp;
   logic [OAW-1:0]          r_out_wp, r_out_rp;
   logic [IAW:0]            r_in_cnt;
   logic [OAW:0]            r_out_cnt;
   logic                    r_in_udf, r_out_ovf;

   logic                    w_rd, w_wr, w_in_push, w_in_pop, w_out_push, w_out_pop;
   logic [IAW:0]            w_in_cnt_nxt;
   logic [PACKET_WIDTH-1:0] w_rd_data;

   assign w_rd         = nicEn & ~nicEnWR;
   assign w_wr         = nicEn & nicEnWR & (addr == 2'b10);
   assign w_in_push    = net_si & net_ri;
   assign w_in_pop     = w_rd & (addr == 2'b00) & (r_in_cnt != '0);
   // Full check uses the pre-edge count, so a same-cycle send never frees room for a write
   assign w_out_push   = w_wr & (r_out_cnt != OUT_FULL);
   assign w_out_pop    = (r_out_cnt != '0) & net_ro & net_polarity;
   assign w_in_cnt_nxt = r_in_cnt + ICW'(w_in_push) - ICW'(w_in_pop);

   always_comb
      w_rd_data = (addr == 2'b00) ? ((r_in_cnt != '0) ? r_in_mem[r_in_rp] : '0) :
                  (addr == 2'b01) ? PACKET_WIDTH'({r_in_udf, r_in_cnt, r_in_cnt != '0}) :
                  (addr == 2'b10) ? '0 :
                                    PACKET_WIDTH'({r_out_ovf, r_out_cnt, r_out_cnt == OUT_FULL});

   always_ff @(posedge clk) begin
      if (w_in_push) r_in_mem[r_in_wp] <= net_di;
      if (w_out_push) r_out_mem[r_out_wp] <= d_in;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_in_wp   <= '0;
         r_in_rp   <= '0;
         r_in_cnt  <= '0;
         r_out_wp  <= '0;
         r_out_rp  <= '0;
         r_out_cnt <= '0;
         r_in_udf  <= 1'b0;
         r_out_ovf <= 1'b0;
         d_out     <= '0;
         net_do    <= '0;
         net_so    <= 1'b0;
         net_ri    <= 1'b1;
      end else begin
         r_in_wp   <= r_in_wp + IAW'(w_in_push);
         r_in_rp   <= r_in_rp + IAW'(w_in_pop);
         r_in_cnt  <= w_in_cnt_nxt;
         net_ri    <= w_in_cnt_nxt < IN_FULL;
         r_out_wp  <= r_out_wp + OAW'(w_out_push);
         r_out_rp  <= r_out_rp + OAW'(w_out_pop);
         r_out_cnt <= r_out_cnt + OCW'(w_out_push) - OCW'(w_out_pop);
         r_in_udf  <= (w_rd & (addr == 2'b01)) ? 1'b0 :
                      (w_rd & (addr == 2'b00) & (r_in_cnt == '0)) ? 1'b1 : r_in_udf;
         r_out_ovf <= (w_rd & (addr == 2'b11)) ? 1'b0 :
                      (w_wr & (r_out_cnt == OUT_FULL)) ? 1'b1 : r_out_ovf;
         if (w_rd) d_out <= w_rd_data;
         net_so    <= w_out_pop;
         if (w_out_pop) net_do <= r_out_mem[r_out_rp];
      end
   end
endmodule

// File: tb/tb_nic_fifo.sv
// tb_nic_fifo: table-driven vectors with a scoreboard for both FIFO paths of nic_fifo.
module tb_nic_fifo;
   localparam int IN_DEPTH  = 4;
   localparam int OUT_DEPTH = 4;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [1:0]  addr = '0;
   logic [63:0] d_in = '0, d_out, net_di = '0, net_do;
   logic        nicEn = 1'b0, nicEnWR = 1'b0, net_si = 1'b0, net_ri, net_so;
   logic        net_ro = 1'b0, net_polarity = 1'b0;

   nic_fifo #(.PACKET_WIDTH(64), .IN_DEPTH(IN_DEPTH), .OUT_DEPTH(OUT_DEPTH)) dut (
      .clk(clk), .reset(reset), .addr(addr), .d_in(d_in), .d_out(d_out),
      .nicEn(nicEn), .nicEnWR(nicEnWR), .net_si(net_si), .net_ri(net_ri),
      .net_di(net_di), .net_so(net_so), .net_ro(net_ro), .net_do(net_do),
      .net_polarity(net_polarity)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        en, wr;
      logic [1:0]  a;
      logic [63:0] din;
      logic        si;
      logic [63:0] di;
      logic        ro, pol, chk;
      logic [63:0] exp;
   } vec_t;

   vec_t        v[$];
   logic [63:0] in_q[$], out_q[$];
   int          oc = 0;
   int          checks = 0, errors = 0;

   task automatic check(string n, logic [63:0] act, logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", n, act, exp);
      end
   endtask

   // One clock; inputs must already be driven. Scoreboards are updated from the pre-edge view.
   task automatic step();
      logic        acc, rd0, wacc, snd;
      logic [63:0] di, dd, e;
      acc  = net_si & net_ri;
      di   = net_di;
      rd0  = nicEn & ~nicEnWR & (addr == 2'b00);
      wacc = nicEn & nicEnWR & (addr == 2'b10) & (oc < OUT_DEPTH);
      dd   = d_in;
      snd  = (oc != 0) & net_ro & net_polarity;
      @(posedge clk);
      #1;
      if (rd0) begin
         e = (in_q.size() != 0) ? in_q.pop_front() : 64'h0;
         check("in_data", d_out, e);
      end
      if (acc) in_q.push_back(di);
      check("net_ri", {63'h0, net_ri}, {63'h0, in_q.size() < IN_DEPTH});
      check("net_so", {63'h0, net_so}, {63'h0, snd});
      if (snd) check("net_do", net_do, out_q.pop_front());
      if (wacc) out_q.push_back(dd);
      oc = oc + int'(wacc) - int'(snd);
   endtask

   task automatic apply(vec_t x, int idx);
      nicEn = x.en; nicEnWR = x.wr; addr = x.a; d_in = x.din;
      net_si = x.si; net_di = x.di; net_ro = x.ro; net_polarity = x.pol;
      step();
      if (x.chk) check($sformatf("vec%0d", idx), d_out, x.exp);
   endtask

   function automatic vec_t mk(logic en, logic wr, logic [1:0] a, logic [63:0] din,
                               logic si, logic [63:0] di, logic ro, logic pol,
                               logic chk, logic [63:0] exp);
      vec_t t;
      t.en = en; t.wr = wr; t.a = a; t.din = din; t.si = si; t.di = di;
      t.ro = ro; t.pol = pol; t.chk = chk; t.exp = exp;
      return t;
   endfunction

   function automatic vec_t rs(logic [1:0] a, logic [63:0] e); return mk(1, 0, a, 0, 0, 0, 0, 0, 1, e); endfunction
   function automatic vec_t rdat(); return mk(1, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0); endfunction
   function automatic vec_t wr(logic [1:0] a, logic [63:0] d); return mk(1, 1, a, d, 0, 0, 0, 0, 0, 0); endfunction
   function automatic vec_t tx(logic pol); return mk(0, 0, 2'b00, 0, 0, 0, 1, pol, 0, 0); endfunction
   function automatic vec_t rx(logic [63:0] d); return mk(0, 0, 2'b00, 0, 1, d, 0, 0, 0, 0); endfunction

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end

   initial begin
      vec_t t;
      repeat (2) @(posedge clk);
      #1;
      check("rst_d_out", d_out, 64'h0);
      check("rst_net_do", net_do, 64'h0);
      check("rst_net_so", {63'h0, net_so}, 64'h0);
      check("rst_net_ri", {63'h0, net_ri}, 64'h1);
      reset = 1'b0;

      v.push_back(rs(2'b01, 64'h0));
      v.push_back(rs(2'b11, 64'h0));
      v.push_back(rs(2'b10, 64'h0));
      v.push_back(rdat());
      v.push_back(rs(2'b01, 64'h10));
      v.push_back(rs(2'b01, 64'h0));
      v.push_back(wr(2'b10, 64'hAAAA_0000_0000_000A));
      v.push_back(wr(2'b10, 64'hBBBB_0000_0000_000B));
      v.push_back(wr(2'b10, 64'hCCCC_0000_0000_000C));
      v.push_back(wr(2'b10, 64'hDDDD_0000_0000_000D));
      v.push_back(wr(2'b10, 64'hEEEE_0000_0000_000E));
      v.push_back(wr(2'b01, 64'h1234));
      v.push_back(rs(2'b11, 64'h19));
      v.push_back(rs(2'b11, 64'h09));
      for (int i = 0; i < 12; i++) v.push_back(tx(i % 2 == 0));
      v.push_back(rs(2'b11, 64'h0));
      v.push_back(rx(64'h0));
      t = rs(2'b01, 64'h3); t.si = 1; t.di = 64'h11; v.push_back(t);
      v.push_back(rx(64'h22));
      v.push_back(rx(64'h33));
      v.push_back(rx(64'h44));
      v.push_back(rx(64'h44));
      t = rs(2'b01, 64'h9); t.si = 1; t.di = 64'h44; v.push_back(t);
      t = rdat(); t.si = 1; t.di = 64'h44; v.push_back(t);
      t = rdat(); t.si = 1; t.di = 64'h44; v.push_back(t);
      v.push_back(rs(2'b01, 64'h7));
      repeat (4) v.push_back(rdat());
      v.push_back(rs(2'b01, 64'h10));
      v.push_back(rs(2'b01, 64'h0));
      v.push_back(rs(2'b11, 64'h0));

      foreach (v[i]) apply(v[i], i);

      // Reset mid-traffic: both FIFOs loaded, a send in flight
      for (int i = 0; i < 4; i++) apply(wr(2'b10, 64'h5000 + 64'(i)), 100 + i);
      for (int i = 0; i < 3; i++) apply(rx(64'h6000 + 64'(i)), 110 + i);
      t = rs(2'b11, 64'h9); t.ro = 1; t.pol = 1;
      apply(t, 120);
      check("pre_rst_so", {63'h0, net_so}, 64'h1);
      #2 reset = 1'b1;
      in_q.delete();
      out_q.delete();
      oc = 0;
      #1;
      check("async_d_out", d_out, 64'h0);
      check("async_net_do", net_do, 64'h0);
      check("async_net_so", {63'h0, net_so}, 64'h0);
      check("async_net_ri", {63'h0, net_ri}, 64'h1);
      repeat (2) @(posedge clk);
      #1;
      check("hold_net_so", {63'h0, net_so}, 64'h0);
      reset = 1'b0;
      t = tx(1'b1);
      for (int i = 0; i < 3; i++) apply(t, 130 + i);
      apply(rs(2'b01, 64'h0), 140);
      apply(rs(2'b11, 64'h0), 141);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
